// File: rtl/vec_decode_stage_if.sv
// Decode-stage bus: D-stage inputs, write-back port and registered E-stage outputs.
// The master side drives the decode/write-back signals; the slave side is the decode stage.
interface vec_decode_stage_if #(
  parameter int LANES = 3,
  parameter int WIDTH = 18,
  parameter int AW    = 4
);
  logic                   stall_d;
  logic                   flush_e;
  logic [31:0]            instr_d;
  logic [WIDTH-1:0]       pc8_d;
  logic [1:0]             reg_src_d;
  logic [1:0]             imm_src_d;
  logic                   reg_write_w;
  logic [AW-1:0]          wa3_w;
  logic [LANES*WIDTH-1:0] wd3_w;
  logic [LANES*WIDTH-1:0] rd1_e;
  logic [LANES*WIDTH-1:0] rd2_e;
  logic [LANES*WIDTH-1:0] ext_imm_e;
  logic [AW-1:0]          ra1_e;
  logic [AW-1:0]          ra2_e;
  logic [AW-1:0]          wa3_e;
  logic                   valid_e;

  modport master (
    output stall_d, flush_e, instr_d, pc8_d, reg_src_d, imm_src_d,
           reg_write_w, wa3_w, wd3_w,
    input  rd1_e, rd2_e, ext_imm_e, ra1_e, ra2_e, wa3_e, valid_e
  );

  modport slave (
    input  stall_d, flush_e, instr_d, pc8_d, reg_src_d, imm_src_d,
           reg_write_w, wa3_w, wd3_w,
    output rd1_e, rd2_e, ext_imm_e, ra1_e, ra2_e, wa3_e, valid_e
  );
endinterface

// File: rtl/vec_decode_stage.sv
// Vector decode stage: field decode, multi-lane register file with R15 = PC+8,
// immediate extension and the Decode/Execute pipeline register.
// Optional macro DECODE_BYPASS_EN: write-first forwarding of the same-cycle
// write-back into the read operands; undefined, reads see the old value.
module vec_decode_stage #(
  parameter int LANES = 3,
  parameter int WIDTH = 18,
  parameter int NREGS = 16
) (
  input logic            clk,
  input logic            rst,
  vec_decode_stage_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int DW = LANES * WIDTH;
  localparam logic [AW-1:0] PC_REG = AW'(15);

  logic [DW-1:0]    rf [NREGS];
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [AW-1:0]    wa3;
  logic [DW-1:0]    rd1;
  logic [DW-1:0]    rd2;
  logic [WIDTH-1:0] imm_lane;
  logic [DW-1:0]    pc8_rep;
  logic             unused_instr;

  // instr[31:24] carries no field this stage consumes
  assign unused_instr = ^bus.instr_d[31:24];
  assign pc8_rep      = {LANES{bus.pc8_d}};

  // Field decode: read addresses and destination, zero-extended to AW
  always_comb begin
    ra1 = bus.reg_src_d[0] ? PC_REG : AW'(bus.instr_d[19:16]);
    ra2 = bus.reg_src_d[1] ? AW'(bus.instr_d[15:12]) : AW'(bus.instr_d[3:0]);
    wa3 = AW'(bus.instr_d[15:12]);
  end

  // Immediate extension, one lane's worth; replicated into every lane on load
  always_comb begin
    imm_lane = '0;
    case (bus.imm_src_d)
      2'b00:   imm_lane = WIDTH'(bus.instr_d[7:0]);
      2'b01:   imm_lane = WIDTH'(bus.instr_d[11:0]);
      2'b10:   imm_lane = WIDTH'($signed({bus.instr_d[23:0], 2'b00}));
      default: imm_lane = '0;
    endcase
  end

  // Asynchronous read ports; R15 always reads as PC+8, never as stored data
  always_comb begin
    rd1 = (ra1 == PC_REG) ? pc8_rep : rf[ra1];
    rd2 = (ra2 == PC_REG) ? pc8_rep : rf[ra2];
`ifdef DECODE_BYPASS_EN
    if (bus.reg_write_w && (bus.wa3_w == ra1) && (ra1 != PC_REG)) rd1 = bus.wd3_w;
    if (bus.reg_write_w && (bus.wa3_w == ra2) && (ra2 != PC_REG)) rd2 = bus.wd3_w;
`endif
  end

  // Register-file write port; writes continue through stall and flush
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (bus.reg_write_w && (bus.wa3_w != PC_REG)) begin
      rf[bus.wa3_w] <= bus.wd3_w;
    end
  end

  // D/E pipeline register: reset, then flush over stall, then load
  always_ff @(posedge clk) begin
    if (rst || bus.flush_e) begin
      bus.rd1_e     <= '0;
      bus.rd2_e     <= '0;
      bus.ext_imm_e <= '0;
      bus.ra1_e     <= '0;
      bus.ra2_e     <= '0;
      bus.wa3_e     <= '0;
      bus.valid_e   <= 1'b0;
    end else if (!bus.stall_d) begin
      bus.rd1_e     <= rd1;
      bus.rd2_e     <= rd2;
      bus.ext_imm_e <= {LANES{imm_lane}};
      bus.ra1_e     <= ra1;
      bus.ra2_e     <= ra2;
      bus.wa3_e     <= wa3;
      bus.valid_e   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vec_decode_stage.sv
// Bench for vec_decode_stage: directed cases plus random traffic against a
// lane-level reference model; a second instance covers a 4x16-bit, 32-entry build.
module tb_vec_decode_stage;
  localparam int LANES = 3;
  localparam int WIDTH = 18;
  localparam int NREGS = 16;
  localparam int AW    = 4;
  localparam int DW    = LANES * WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  vec_decode_stage_if #(.LANES(LANES), .WIDTH(WIDTH), .AW(AW)) ifc ();
  vec_decode_stage #(.LANES(LANES), .WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .bus(ifc));

  vec_decode_stage_if #(.LANES(4), .WIDTH(16), .AW(5)) ifc2 ();
  vec_decode_stage #(.LANES(4), .WIDTH(16), .NREGS(32)) dut2 (
    .clk(clk), .rst(rst2), .bus(ifc2));

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] mrf [NREGS][LANES];
  logic [DW-1:0]    e_rd1, e_rd2, e_imm;
  int               e_ra1, e_ra2, e_wa3;
  logic             e_valid;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int ra);
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++)
      v[l*WIDTH +: WIDTH] = (ra == 15) ? ifc.pc8_d : mrf[ra][l];
`ifdef DECODE_BYPASS_EN
    if (ifc.reg_write_w && (int'(ifc.wa3_w) == ra) && (ra != 15)) v = ifc.wd3_w;
`endif
    return v;
  endfunction

  function automatic logic [DW-1:0] m_imm();
    longint x;
    logic [DW-1:0] v;
    case (ifc.imm_src_d)
      2'd0:    x = longint'(ifc.instr_d[7:0]);
      2'd1:    x = longint'(ifc.instr_d[11:0]);
      2'd2:    begin x = $signed(ifc.instr_d[23:0]); x = x * 4; end
      default: x = 0;
    endcase
    for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = x[WIDTH-1:0];
    return v;
  endfunction

  // One clock of the model, then the clock, then compare every E output
  task automatic step();
    int a1, a2;
    logic [DW-1:0] r1, r2;
    if (rst) begin
      for (int r = 0; r < NREGS; r++)
        for (int l = 0; l < LANES; l++) mrf[r][l] = '0;
      e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_ra1 = 0; e_ra2 = 0; e_wa3 = 0; e_valid = 1'b0;
    end else begin
      a1 = ifc.reg_src_d[0] ? 15 : int'(ifc.instr_d[19:16]);
      a2 = ifc.reg_src_d[1] ? int'(ifc.instr_d[15:12]) : int'(ifc.instr_d[3:0]);
      r1 = m_read(a1);
      r2 = m_read(a2);
      if (ifc.flush_e) begin
        e_rd1 = '0; e_rd2 = '0; e_imm = '0; e_ra1 = 0; e_ra2 = 0; e_wa3 = 0; e_valid = 1'b0;
      end else if (!ifc.stall_d) begin
        e_rd1 = r1; e_rd2 = r2; e_imm = m_imm();
        e_ra1 = a1; e_ra2 = a2; e_wa3 = int'(ifc.instr_d[15:12]); e_valid = 1'b1;
      end
      if (ifc.reg_write_w && ifc.wa3_w != 4'd15)
        for (int l = 0; l < LANES; l++) mrf[ifc.wa3_w][l] = ifc.wd3_w[l*WIDTH +: WIDTH];
    end
    @(posedge clk); #1;
    chk("valid_e", ifc.valid_e, e_valid);
    chk("rd1_e", ifc.rd1_e, e_rd1);
    chk("rd2_e", ifc.rd2_e, e_rd2);
    chk("ext_imm_e", ifc.ext_imm_e, e_imm);
    chk("ra1_e", ifc.ra1_e, e_ra1);
    chk("ra2_e", ifc.ra2_e, e_ra2);
    chk("wa3_e", ifc.wa3_e, e_wa3);
  endtask

  task automatic idle_inputs();
    ifc.stall_d = 0; ifc.flush_e = 0; ifc.instr_d = '0; ifc.pc8_d = '0;
    ifc.reg_src_d = 0; ifc.imm_src_d = 0; ifc.reg_write_w = 0; ifc.wa3_w = '0; ifc.wd3_w = '0;
  endtask

  task automatic rand_inputs();
    ifc.instr_d     = $urandom;
    ifc.pc8_d       = WIDTH'($urandom);
    ifc.reg_src_d   = 2'($urandom);
    ifc.imm_src_d   = 2'($urandom);
    ifc.reg_write_w = $urandom_range(1, 0) == 1;
    ifc.wa3_w       = AW'($urandom);
    ifc.wd3_w       = {$urandom, $urandom};
    ifc.stall_d     = $urandom_range(99, 0) < 15;
    ifc.flush_e     = $urandom_range(99, 0) < 10;
  endtask

  task automatic step2();
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] held;

  initial begin
    rst = 1; rst2 = 1;
    idle_inputs();
    ifc2.stall_d = 0; ifc2.flush_e = 0; ifc2.instr_d = '0; ifc2.pc8_d = '0;
    ifc2.reg_src_d = 0; ifc2.imm_src_d = 0; ifc2.reg_write_w = 0; ifc2.wa3_w = '0; ifc2.wd3_w = '0;
    #1;

    // Reset with arbitrary inputs, then every R0..R14 reads zero
    rand_inputs(); step();
    rand_inputs(); step();
    chk("rst_valid", ifc.valid_e, 1'b0);
    chk("rst_rd1", ifc.rd1_e, '0);
    rst = 0;
    idle_inputs();
    for (int r = 0; r < 15; r++) begin
      ifc.instr_d = 32'(r) << 16;
      step();
      chk("rst_r_zero", ifc.rd1_e, '0);
    end

    // Same-cycle write/read hazard on R5
    ifc.instr_d = 32'h0000_0005; ifc.reg_write_w = 1; ifc.wa3_w = 4'd5;
    ifc.wd3_w = {3{18'h00ABC}};
    step();
`ifdef DECODE_BYPASS_EN
    chk("hazard_r5", ifc.rd2_e, {3{18'h00ABC}});
`else
    chk("hazard_r5", ifc.rd2_e, '0);
`endif

    // Write R3 with distinct lanes, read it back next cycle
    ifc.instr_d = '0; ifc.wa3_w = 4'd3; ifc.wd3_w = {18'h3FFFF, 18'h00001, 18'h15555};
    step();
    ifc.reg_write_w = 0; ifc.instr_d = 32'h0003_0000;
    step();
    chk("r3_lanes", ifc.rd1_e, {18'h3FFFF, 18'h00001, 18'h15555});

    // R15 write is dropped; reads return PC+8 in every lane
    ifc.reg_write_w = 1; ifc.wa3_w = 4'd15; ifc.wd3_w = {3{18'h00001}};
    ifc.reg_src_d = 2'b01; ifc.pc8_d = 18'h00108;
    step();
    chk("r15_pc8", ifc.rd1_e, {3{18'h00108}});
    ifc.reg_write_w = 0;
    step();
    chk("r15_pc8_after", ifc.rd1_e, {3{18'h00108}});

    // Immediate formats
    ifc.reg_src_d = 0; ifc.instr_d = 32'h00FF_FFFE; ifc.imm_src_d = 2'b10;
    step();
    chk("imm_branch", ifc.ext_imm_e, {3{18'h3FFF8}});
    ifc.instr_d = 32'h0000_08FF; ifc.imm_src_d = 2'b01;
    step();
    chk("imm_12", ifc.ext_imm_e, {3{18'h008FF}});

    // Stall for 3 cycles while instr changes and R7 is written back
    ifc.imm_src_d = 0; ifc.instr_d = 32'h0003_0000;
    step();
    held = ifc.rd1_e;
    for (int c = 0; c < 3; c++) begin
      ifc.stall_d = 1; ifc.instr_d = $urandom;
      ifc.reg_write_w = (c == 0); ifc.wa3_w = 4'd7; ifc.wd3_w = {18'h12345, 18'h2AAAA, 18'h00777};
      step();
      chk("stall_frozen", ifc.rd1_e, held);
    end
    ifc.stall_d = 0; ifc.reg_write_w = 0; ifc.reg_src_d = 0; ifc.instr_d = 32'h0007_0000;
    step();
    chk("stall_wb_landed", ifc.rd1_e, {18'h12345, 18'h2AAAA, 18'h00777});

    // Stall and flush together: flush wins
    ifc.stall_d = 1; ifc.flush_e = 1;
    step();
    chk("flush_valid", ifc.valid_e, 1'b0);
    chk("flush_rd1", ifc.rd1_e, '0);
    idle_inputs();

    // Random traffic, including resets mid-stream
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      rst = $urandom_range(99, 0) < 3;
      step();
    end
    rst = 0;

    // Wider build: 4 lanes x 16 bits, 32 registers
    step2();
    chk("sw_rst_valid", ifc2.valid_e, 1'b0);
    rst2 = 0;
    ifc2.reg_write_w = 1; ifc2.wa3_w = 5'd19; ifc2.wd3_w = 64'h1111_2222_3333_4444;
    ifc2.instr_d = '0;
    step2();
    ifc2.reg_write_w = 0; ifc2.instr_d = 32'h0003_0000;
    step2();
    chk("sw_r3_not_r19", ifc2.rd1_e, 64'h0);
    chk("sw_ra1_5bit", ifc2.ra1_e, 5'd3);
    ifc2.reg_write_w = 1; ifc2.wa3_w = 5'd3; ifc2.wd3_w = 64'hAAAA_BBBB_CCCC_DDDD;
    ifc2.instr_d = '0;
    step2();
    ifc2.reg_write_w = 0; ifc2.instr_d = 32'h0003_000F; ifc2.pc8_d = 16'hBEEF;
    ifc2.imm_src_d = 2'b10;
    step2();
    chk("sw_r3_lanes", ifc2.rd1_e, 64'hAAAA_BBBB_CCCC_DDDD);
    chk("sw_r15_pc8", ifc2.rd2_e, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("sw_ra2_5bit", ifc2.ra2_e, 5'd15);
    ifc2.instr_d = 32'h00FF_FFFE;
    step2();
    chk("sw_imm", ifc2.ext_imm_e, 64'hFFF8_FFF8_FFF8_FFF8);
    chk("sw_valid", ifc2.valid_e, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
